load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 195 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : RV64 load/store engine. It takes one core request, checks the
//            funct3 and the alignment, and runs a single doubleword bus
//            transaction with byte strobes and a timeout. Load data is
//            extracted from its lane and sign- or zero-extended.
// Revision : 1.0 - initial release
// Ports    : i_Clock, i_Reset         clock; asynchronous active-high reset
//            i_Start, i_MemRead,
//            i_MemWrite, i_Funct3,
//            i_Addr, i_WriteData      core request (sampled in IDLE)
//            o_Busy, o_Done, o_Fault,
//            o_ReadData               core status and load result
//            o_BusReq, o_BusWe,
//            o_BusAddr, o_BusWdata,
//            o_BusStrb                bus request side
//            i_BusAck, i_BusRdata     bus completion side
// ============================================================================
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Start,
  input  logic        i_MemRead,
  input  logic        i_MemWrite,
  input  logic [2:0]  i_Funct3,
  input  logic [63:0] i_Addr,
  input  logic [63:0] i_WriteData,
  output logic        o_Busy,
  output logic        o_Done,
  output logic        o_Fault,
  output logic [63:0] o_ReadData,
  output logic        o_BusReq,
  output logic        o_BusWe,
  output logic [63:0] o_BusAddr,
  output logic [63:0] o_BusWdata,
  output logic [7:0]  o_BusStrb,
  input  logic        i_BusAck,
  input  logic [63:0] i_BusRdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // The counter reads TIMEOUT-1 during the last REQ cycle that may still
  // accept an ack.
  localparam logic [CW-1:0] c_TIMEOUT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_count;
  logic          r_we;
  logic          r_fault;
  logic [2:0]    r_funct3;
  logic [2:0]    r_off;
  logic [60:0]   r_addr_dw;
  logic [7:0]    r_strb;
  logic [63:0]   r_wdata;
  logic [63:0]   r_rdata;

  // Request decode, evaluated on the live inputs while in IDLE.
  logic [1:0]  w_size;
  logic        w_one_op;
  logic        w_f3_ok;
  logic        w_misalign;
  logic        w_req_fault;
  logic [7:0]  w_mask8;
  logic [63:0] w_mask64;
  logic [7:0]  w_strb;
  logic [63:0] w_wdata;
  logic [63:0] w_lane;
  logic [63:0] w_load_ext;

  assign w_size      = i_Funct3[1:0];
  assign w_one_op    = i_MemRead ^ i_MemWrite;
  // Stores have no unsigned variants; for loads only 111 is undefined.
  assign w_f3_ok     = i_MemWrite ? ~i_Funct3[2] : (i_Funct3 != 3'b111);
  assign w_req_fault = ~w_f3_ok | w_misalign;

  always_comb begin
    w_misalign = 1'b0;
    w_mask8    = 8'h01;
    w_mask64   = 64'h0000_0000_0000_00FF;
    case (w_size)
      2'd1: begin
        w_misalign = i_Addr[0];
        w_mask8    = 8'h03;
        w_mask64   = 64'h0000_0000_0000_FFFF;
      end
      2'd2: begin
        w_misalign = |i_Addr[1:0];
        w_mask8    = 8'h0F;
        w_mask64   = 64'h0000_0000_FFFF_FFFF;
      end
      2'd3: begin
        w_misalign = |i_Addr[2:0];
        w_mask8    = 8'hFF;
        w_mask64   = 64'hFFFF_FFFF_FFFF_FFFF;
      end
      default: begin
        w_misalign = 1'b0;
        w_mask8    = 8'h01;
        w_mask64   = 64'h0000_0000_0000_00FF;
      end
    endcase
  end

  // Aligned accesses never cross the doubleword, so nothing shifts out.
  assign w_strb  = w_mask8 << i_Addr[2:0];
  assign w_wdata = (i_WriteData & w_mask64) << {i_Addr[2:0], 3'b000};

  // Load extraction uses the latched offset/funct3, not the live inputs.
  assign w_lane = i_BusRdata >> {r_off, 3'b000};

  always_comb begin
    w_load_ext = w_lane;
    case (r_funct3)
      3'b000:  w_load_ext = {{56{w_lane[7]}},  w_lane[7:0]};
      3'b001:  w_load_ext = {{48{w_lane[15]}}, w_lane[15:0]};
      3'b010:  w_load_ext = {{32{w_lane[31]}}, w_lane[31:0]};
      3'b100:  w_load_ext = {56'd0, w_lane[7:0]};
      3'b101:  w_load_ext = {48'd0, w_lane[15:0]};
      3'b110:  w_load_ext = {32'd0, w_lane[31:0]};
      default: w_load_ext = w_lane;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_we      <= 1'b0;
      r_fault   <= 1'b0;
      r_funct3  <= 3'd0;
      r_off     <= 3'd0;
      r_addr_dw <= '0;
      r_strb    <= 8'd0;
      r_wdata   <= 64'd0;
      r_rdata   <= 64'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_Start && w_one_op) begin
            r_we      <= i_MemWrite;
            r_funct3  <= i_Funct3;
            r_off     <= i_Addr[2:0];
            r_addr_dw <= i_Addr[63:3];
            r_strb    <= w_strb;
            r_wdata   <= i_MemWrite ? w_wdata : 64'd0;
            r_count   <= '0;
            r_fault   <= w_req_fault;
            // Bad requests skip the bus entirely.
            r_state   <= w_req_fault ? S_DONE : S_REQ;
          end
        end
        S_REQ: begin
          if (i_BusAck) begin
            if (!r_we) begin
              r_rdata <= w_load_ext;
            end
            r_state <= S_DONE;
          end else begin
            r_count <= r_count + 1'b1;
            if (r_count == c_TIMEOUT_LAST) begin
              r_fault <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode straight from registers, so reset clears them without a clock.
  assign o_Busy     = (r_state == S_REQ) || (r_state == S_DONE);
  assign o_Done     = (r_state == S_DONE);
  assign o_Fault    = (r_state == S_DONE) && r_fault;
  assign o_ReadData = r_rdata;
  assign o_BusReq   = (r_state == S_REQ);
  assign o_BusWe    = (r_state == S_REQ) && r_we;
  assign o_BusStrb  = (r_state == S_REQ) ? r_strb : 8'd0;
  assign o_BusAddr  = {r_addr_dw, 3'b000};
  assign o_BusWdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Self-checking bench for load_store_unit. It applies a table of
//            directed accesses with hand-computed results, a mid-access reset
//            sequence, and random accesses that are scored against a
//            byte-level reference model.
// Revision : 1.0 - initial release
// Ports    : none
// ============================================================================
module tb_load_store_unit;

  localparam int TO = 4;

  logic        i_Clock = 1'b0;
  logic        i_Reset;
  logic        i_Start;
  logic        i_MemRead;
  logic        i_MemWrite;
  logic [2:0]  i_Funct3;
  logic [63:0] i_Addr;
  logic [63:0] i_WriteData;
  logic        o_Busy;
  logic        o_Done;
  logic        o_Fault;
  logic [63:0] o_ReadData;
  logic        o_BusReq;
  logic        o_BusWe;
  logic [63:0] o_BusAddr;
  logic [63:0] o_BusWdata;
  logic [7:0]  o_BusStrb;
  logic        i_BusAck;
  logic [63:0] i_BusRdata;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .i_Clock    (i_Clock),
    .i_Reset    (i_Reset),
    .i_Start    (i_Start),
    .i_MemRead  (i_MemRead),
    .i_MemWrite (i_MemWrite),
    .i_Funct3   (i_Funct3),
    .i_Addr     (i_Addr),
    .i_WriteData(i_WriteData),
    .o_Busy     (o_Busy),
    .o_Done     (o_Done),
    .o_Fault    (o_Fault),
    .o_ReadData (o_ReadData),
    .o_BusReq   (o_BusReq),
    .o_BusWe    (o_BusWe),
    .o_BusAddr  (o_BusAddr),
    .o_BusWdata (o_BusWdata),
    .o_BusStrb  (o_BusStrb),
    .i_BusAck   (i_BusAck),
    .i_BusRdata (i_BusRdata)
  );

  always #5 i_Clock = ~i_Clock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wd;
    logic [63:0] rdat;
    int          dly;    // REQ cycles before ack; >= TO means withheld
    bit          mid;    // pulse i_Start while the access is in flight
    bit          fpre;   // expected fault before any bus request
    logic [7:0]  strb;
    logic [63:0] wdata;
    logic [63:0] rdata;  // expected o_ReadData after the access
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rd, bit wr, logic [2:0] f3, logic [63:0] addr,
                              logic [63:0] wd, logic [63:0] rdat, int dly, bit mid,
                              bit fpre, logic [7:0] strb, logic [63:0] wdata,
                              logic [63:0] rdata);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wd = wd; v.rdat = rdat;
    v.dly = dly; v.mid = mid; v.fpre = fpre; v.strb = strb; v.wdata = wdata;
    v.rdata = rdata;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%b want=%b at %0t", nm, act, exp, $time);
    end
  endtask

  // Entered and left just after a rising edge with the DUT idle.
  task automatic run_access(input vec_t v);
    int  k;
    bit  acked;
    bit  valid;
    valid = v.rd ^ v.wr;
    i_Start = 1'b1; i_MemRead = v.rd; i_MemWrite = v.wr;
    i_Funct3 = v.f3; i_Addr = v.addr; i_WriteData = v.wd;
    @(posedge i_Clock); #1;
    // Scramble the request inputs: the DUT must work from its latched copy.
    i_Start = 1'b0;
    i_Addr = {$urandom, $urandom}; i_WriteData = {$urandom, $urandom};
    i_Funct3 = 3'($urandom); i_MemRead = 1'($urandom); i_MemWrite = 1'($urandom);
    if (!valid) begin
      @(negedge i_Clock);
      chk1("ignored_busy", o_Busy, 1'b0);
      chk1("ignored_busreq", o_BusReq, 1'b0);
      chk("ignored_rdata", o_ReadData, v.rdata);
      @(posedge i_Clock); #1;
      return;
    end
    acked = 1'b0;
    if (!v.fpre) begin
      if (v.mid) begin
        i_Start = 1'b1; i_MemRead = 1'b1; i_MemWrite = 1'b0; i_Funct3 = 3'd0;
      end
      k = 0;
      while (1) begin
        @(negedge i_Clock);
        chk1("req_busreq", o_BusReq, 1'b1);
        chk1("req_busy", o_Busy, 1'b1);
        chk1("req_done", o_Done, 1'b0);
        chk1("req_we", o_BusWe, v.wr);
        chk("req_addr", o_BusAddr, {v.addr[63:3], 3'b000});
        chk("req_strb", 64'(o_BusStrb), 64'(v.strb));
        if (v.wr) chk("req_wdata", o_BusWdata, v.wdata);
        if (k == v.dly) begin
          i_BusAck = 1'b1; i_BusRdata = v.rdat; acked = 1'b1;
        end
        @(posedge i_Clock); #1;
        i_BusAck = 1'b0; i_BusRdata = {$urandom, $urandom};
        if (acked || k == TO - 1) break;
        k++;
      end
      i_Start = 1'b0;
    end
    @(negedge i_Clock);
    chk1("done_pulse", o_Done, 1'b1);
    chk1("done_fault", o_Fault, v.fpre || !acked);
    chk1("done_busreq", o_BusReq, 1'b0);
    chk1("done_busy", o_Busy, 1'b1);
    chk("done_strb", 64'(o_BusStrb), 64'd0);
    chk("done_rdata", o_ReadData, v.rdata);
    // A stray or late ack must have no effect.
    i_BusAck = 1'b1; i_BusRdata = {$urandom, $urandom};
    @(posedge i_Clock); #1;
    i_BusAck = 1'b0;
    @(negedge i_Clock);
    chk1("after_done", o_Done, 1'b0);
    chk1("after_busy", o_Busy, 1'b0);
    chk1("after_busreq", o_BusReq, 1'b0);
    chk("after_rdata", o_ReadData, v.rdata);
    @(posedge i_Clock); #1;
  endtask

  // Reference model: byte-by-byte description of an RV64 access.
  function automatic vec_t model(bit rd, bit wr, logic [2:0] f3, logic [63:0] addr,
                                 logic [63:0] wd, logic [63:0] rdat, int dly,
                                 logic [63:0] prev);
    vec_t v;
    int n;
    int off;
    bit ok;
    n = 1 << f3[1:0];
    off = int'(addr[2:0]);
    ok = (wr ? (f3 <= 3'd3) : (f3 != 3'd7)) && ((off % n) == 0);
    v = mk(rd, wr, f3, addr, wd, rdat, dly, 1'b0, !ok, 8'd0, 64'd0, prev);
    if (ok) begin
      for (int i = 0; i < n; i++) begin
        v.strb[off + i] = 1'b1;
        v.wdata[8*(off + i) +: 8] = wd[8*i +: 8];
      end
      if (rd && !wr && dly < TO) begin
        v.rdata = 64'd0;
        for (int i = 0; i < n; i++) v.rdata[8*i +: 8] = rdat[8*(off + i) +: 8];
        if (!f3[2] && n < 8 && v.rdata[8*n - 1])
          for (int i = 8*n; i < 64; i++) v.rdata[i] = 1'b1;
      end
    end
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [63:0] exp_rd;
    i_Reset = 1'b1; i_Start = 1'b0; i_MemRead = 1'b0; i_MemWrite = 1'b0;
    i_Funct3 = 3'd0; i_Addr = 64'd0; i_WriteData = 64'd0;
    i_BusAck = 1'b0; i_BusRdata = 64'd0;
    #2;
    chk1("rst_busy", o_Busy, 1'b0);
    chk1("rst_done", o_Done, 1'b0);
    chk1("rst_fault", o_Fault, 1'b0);
    chk1("rst_busreq", o_BusReq, 1'b0);
    chk1("rst_we", o_BusWe, 1'b0);
    chk("rst_strb", 64'(o_BusStrb), 64'd0);
    chk("rst_addr", o_BusAddr, 64'd0);
    chk("rst_wdata", o_BusWdata, 64'd0);
    chk("rst_rdata", o_ReadData, 64'd0);
    #10 i_Reset = 1'b0;
    @(posedge i_Clock); #1;

    //          rd wr f3    addr         wd                     rdat                   dly mid fpre strb   wdata                  rdata
    tbl.push_back(mk(1,0,3'd0,64'h1003,64'h0,               64'h0000_0000_8000_0000,0, 0,0,8'h08,64'h0,               64'hFFFF_FFFF_FFFF_FF80));
    tbl.push_back(mk(0,1,3'd1,64'h2006,64'hABCD,            64'h0,                  1, 0,0,8'hC0,64'hABCD_0000_0000_0000,64'hFFFF_FFFF_FFFF_FF80));
    tbl.push_back(mk(1,0,3'd2,64'h3002,64'h0,               64'h0,                  0, 0,1,8'h00,64'h0,               64'hFFFF_FFFF_FFFF_FF80));
    tbl.push_back(mk(1,0,3'd3,64'h0008,64'h0,               64'h1234,               TO,0,0,8'hFF,64'h0,               64'hFFFF_FFFF_FFFF_FF80));
    tbl.push_back(mk(1,0,3'd5,64'h0000,64'h0,               64'h8001,               2, 1,0,8'h03,64'h0,               64'h0000_0000_0000_8001));
    tbl.push_back(mk(1,0,3'd3,64'h0010,64'h0,               64'h1122_3344_5566_7788,TO-1,0,0,8'hFF,64'h0,             64'h1122_3344_5566_7788));
    tbl.push_back(mk(1,0,3'd6,64'h0004,64'h0,               64'h89AB_CDEF_0000_0000,0, 0,0,8'hF0,64'h0,               64'h0000_0000_89AB_CDEF));
    tbl.push_back(mk(1,0,3'd2,64'h0004,64'h0,               64'h89AB_CDEF_0000_0000,1, 0,0,8'hF0,64'h0,               64'hFFFF_FFFF_89AB_CDEF));
    tbl.push_back(mk(0,1,3'd3,64'h0018,64'hDEAD_BEEF_CAFE_F00D,64'h0,               0, 0,0,8'hFF,64'hDEAD_BEEF_CAFE_F00D,64'hFFFF_FFFF_89AB_CDEF));
    tbl.push_back(mk(0,1,3'd0,64'h0007,64'hFFFF_FF5A,       64'h0,                  0, 0,0,8'h80,64'h5A00_0000_0000_0000,64'hFFFF_FFFF_89AB_CDEF));
    tbl.push_back(mk(0,1,3'd4,64'h0000,64'h1,               64'h0,                  0, 0,1,8'h00,64'h0,               64'hFFFF_FFFF_89AB_CDEF));
    tbl.push_back(mk(1,0,3'd7,64'h0000,64'h0,               64'h0,                  0, 0,1,8'h00,64'h0,               64'hFFFF_FFFF_89AB_CDEF));
    tbl.push_back(mk(1,1,3'd0,64'h0000,64'h0,               64'h0,                  0, 0,0,8'h00,64'h0,               64'hFFFF_FFFF_89AB_CDEF));
    tbl.push_back(mk(1,0,3'd1,64'h0001,64'h0,               64'h0,                  0, 0,1,8'h00,64'h0,               64'hFFFF_FFFF_89AB_CDEF));
    tbl.push_back(mk(1,0,3'd4,64'h0005,64'h0,               64'h0000_8000_0000_0000,0, 0,0,8'h20,64'h0,               64'h0000_0000_0000_0080));

    foreach (tbl[i]) run_access(tbl[i]);

    // Reset lands between edges while a load is waiting on the bus.
    i_Start = 1'b1; i_MemRead = 1'b1; i_MemWrite = 1'b0;
    i_Funct3 = 3'd3; i_Addr = 64'h40;
    @(posedge i_Clock); #1;
    i_Start = 1'b0;
    @(negedge i_Clock);
    chk1("pre_rst_busreq", o_BusReq, 1'b1);
    #2 i_Reset = 1'b1;
    #1;
    chk1("mid_rst_busreq", o_BusReq, 1'b0);
    chk1("mid_rst_busy", o_Busy, 1'b0);
    chk("mid_rst_rdata", o_ReadData, 64'd0);
    chk("mid_rst_addr", o_BusAddr, 64'd0);
    i_BusAck = 1'b1; i_BusRdata = 64'hFFFF_0000_FFFF_0000;
    @(posedge i_Clock); #1;
    i_Reset = 1'b0;
    @(posedge i_Clock); #1;
    i_BusAck = 1'b0;
    @(negedge i_Clock);
    chk1("post_rst_busy", o_Busy, 1'b0);
    chk1("post_rst_done", o_Done, 1'b0);
    chk1("post_rst_busreq", o_BusReq, 1'b0);
    chk("post_rst_rdata", o_ReadData, 64'd0);
    @(posedge i_Clock); #1;

    // Random accesses scored against the model.
    exp_rd = 64'd0;
    for (int t = 0; t < 200; t++) begin
      int sel;
      bit rd, wr;
      logic [2:0] f3;
      logic [63:0] addr;
      sel = int'($urandom_range(0, 7));
      rd = (sel < 6) ? (sel % 2 == 0) : (sel == 6);
      wr = (sel < 6) ? (sel % 2 == 1) : (sel == 6);
      f3 = 3'($urandom);
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0)
        addr[2:0] = addr[2:0] & ~(3'((1 << f3[1:0]) - 1));
      v = model(rd, wr, f3, addr, {$urandom, $urandom}, {$urandom, $urandom},
                int'($urandom_range(0, TO)), exp_rd);
      v.mid = 1'($urandom);
      run_access(v);
      exp_rd = v.rdata;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
